// File: rtl/seg7_display_ctrl_if.sv
// Bus between the status datapath and the 7-segment display driver.
// The master loads values and drives the blink mask; the slave reports busy/done and drives the pins.
interface seg7_display_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   data;
  logic                      dec_mode;
  logic                      blank_lz;
  logic [NUM_DIGITS-1:0]     blink_mask;
  logic                      busy;
  logic                      done;
  logic [7*NUM_DIGITS-1:0]   oSEG;

  modport master (
    output load, data, dec_mode, blank_lz, blink_mask,
    input  busy, done, oSEG
  );

  modport slave (
    input  load, data, dec_mode, blank_lz, blink_mask,
    output busy, done, oSEG
  );
endinterface

// File: rtl/seg7_display_ctrl.sv
// Registered driver for NUM_DIGITS active-low 7-segment digits: hex or decimal (shift-add-3 BCD)
// display with load-and-hold, leading-zero blanking and per-digit blinking.
module seg7_display_ctrl #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned BIN_W      = 26,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input  logic               Clk,
  input  logic               Reset,
  seg7_display_ctrl_if.slave bus
);

  localparam int unsigned DW     = 4 * NUM_DIGITS;
  localparam int unsigned SW     = 7 * NUM_DIGITS;
  localparam int unsigned CntW   = $clog2(BIN_W + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_DIV);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg7_display_ctrl: NUM_DIGITS must be 1..8");
  end
  if (BLINK_DIV < 2) begin : g_bad_blink
    $error("seg7_display_ctrl: BLINK_DIV must be >= 2");
  end
  if (BIN_W < 1 || BIN_W > 32 || ((64'd1 << BIN_W) - 64'd1) >= pow10(NUM_DIGITS)) begin : g_bad_binw
    $error("seg7_display_ctrl: 2^BIN_W-1 must fit in NUM_DIGITS decimal digits");
  end

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  typedef enum logic {StIdle, StConv} state_e;

  state_e            state_q;
  logic [BIN_W-1:0]  shift_q;
  logic [DW-1:0]     bcd_q;
  logic [DW-1:0]     bcd_d;
  logic [CntW-1:0]   cnt_q;
  logic [DW-1:0]     digit_q;
  logic              lz_q;
  logic              lz_pend_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic [BlinkW-1:0] blink_cnt_q;
  logic              phase_q;
  logic [SW-1:0]     seg_q;
  logic [SW-1:0]     seg_d;

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the next binary MSB.
  always_comb begin
    logic [DW-1:0] bcd_adj;
    bcd_adj = bcd_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    bcd_d = {bcd_adj[DW-2:0], shift_q[BIN_W-1]};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      digit_q   <= '0;
      lz_q      <= 1'b0;
      lz_pend_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.load) begin
            if (bus.dec_mode) begin
              shift_q   <= bus.data[BIN_W-1:0];
              bcd_q     <= '0;
              cnt_q     <= '0;
              lz_pend_q <= bus.blank_lz;
              busy_q    <= 1'b1;
              state_q   <= StConv;
            end else begin
              digit_q <= bus.data;
              lz_q    <= bus.blank_lz;
              valid_q <= 1'b1;
              done_q  <= 1'b1;
            end
          end
        end
        StConv: begin
          bcd_q   <= bcd_d;
          shift_q <= shift_q << 1;
          // The last shift and the commit happen on the same edge.
          if (cnt_q == CntW'(BIN_W - 1)) begin
            digit_q <= bcd_d;
            lz_q    <= lz_pend_q;
            valid_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BlinkW'(1);
    end
  end

  // Walk from the top digit down; a digit is a leading zero until a nonzero digit has been seen.
  always_comb begin
    logic       seen;
    logic [3:0] nib;
    logic       hide;
    seg_d = '1;
    seen  = 1'b0;
    nib   = 4'd0;
    hide  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib  = digit_q[4*k +: 4];
      seen = seen | (nib != 4'd0);
      hide = !valid_q || (lz_q && !seen && k != 0) || (phase_q && bus.blink_mask[k]);
      seg_d[7*k +: 7] = hide ? 7'h7F : glyph(nib);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) seg_q <= '1;
    else       seg_q <= seg_d;
  end

  assign bus.oSEG = seg_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Bench for seg7_display_ctrl: arithmetic reference model compared every cycle, plus directed
// vectors with hand-computed display images.
module tb_seg7_display_ctrl;
  localparam int unsigned ND = 8;
  localparam int unsigned BW = 26;
  localparam int unsigned BD = 4;

  localparam logic [6:0] Glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [55:0] AllBlank = {8{7'h7F}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmp_en = 1'b0;

  seg7_display_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg7_display_ctrl #(
    .NUM_DIGITS(ND),
    .BIN_W     (BW),
    .BLINK_DIV (BD)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_total = 0;
  int busy_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: display contents as decimal/hex digit values, phase from elapsed cycles.
  int          m_dig [ND];
  bit          m_lz;
  bit          m_valid;
  bit          m_done;
  int          m_busy_left;
  int unsigned m_pend;
  bit          m_pend_lz;
  int unsigned m_edges;
  logic [55:0] m_seg = AllBlank;

  initial begin
    foreach (m_dig[k]) m_dig[k] = 0;
    m_lz = 0; m_valid = 0; m_done = 0; m_busy_left = 0; m_pend = 0; m_pend_lz = 0; m_edges = 0;
  end

  function automatic logic [55:0] model_seg(input logic [7:0] mask);
    logic [55:0] s;
    int msnz = 0;
    bit phase;
    phase = ((m_edges / BD) % 2) == 1;
    for (int k = 0; k < ND; k++) if (m_dig[k] != 0) msnz = k;
    for (int k = 0; k < ND; k++)
      s[7*k +: 7] = (!m_valid || (m_lz && k > msnz) || (phase && mask[k])) ? 7'h7F : Glyph[m_dig[k]];
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_dig[k]) m_dig[k] = 0;
      m_lz = 0; m_valid = 0; m_done = 0; m_busy_left = 0; m_edges = 0;
      m_seg = AllBlank;
    end else begin
      m_seg  = model_seg(bus.blink_mask);
      m_done = 0;
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          int unsigned v;
          v = m_pend;
          for (int k = 0; k < ND; k++) begin
            m_dig[k] = int'(v % 10);
            v = v / 10;
          end
          m_lz = m_pend_lz; m_valid = 1; m_done = 1;
        end
      end else if (bus.load) begin
        if (bus.dec_mode) begin
          m_busy_left = BW;
          m_pend      = 32'(bus.data[BW-1:0]);
          m_pend_lz   = bus.blank_lz;
        end else begin
          for (int k = 0; k < ND; k++) m_dig[k] = int'(bus.data[4*k +: 4]);
          m_lz = bus.blank_lz; m_valid = 1; m_done = 1;
        end
      end
      m_edges++;
    end
  end

  always @(negedge clk) begin
    if (bus.done) done_total++;
    if (bus.busy) busy_total++;
    if (cmp_en) begin
      check("model_oseg", 64'(bus.oSEG), 64'(m_seg));
      check("model_busy", 64'(bus.busy), 64'(m_busy_left > 0));
      check("model_done", 64'(bus.done), 64'(m_done));
    end
  end

  task automatic load_pulse(input logic [31:0] d, input logic dec, input logic lz);
    @(posedge clk);
    #2;
    bus.load = 1'b1; bus.data = d; bus.dec_mode = dec; bus.blank_lz = lz;
    @(posedge clk);
    #2;
    bus.load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, b0, blanks, bad_upper;
    bus.load = 1'b0; bus.data = '0; bus.dec_mode = 1'b0; bus.blank_lz = 1'b0;
    bus.blink_mask = '0;
    @(posedge clk);
    cmp_en = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    check("reset_oseg", 64'(bus.oSEG), 64'(AllBlank));
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);

    // Hex with leading-zero blanking
    load_pulse(32'h0000BEEF, 1'b0, 1'b1);
    @(negedge clk);
    check("hex_done_pulse", 64'(bus.done), 64'd1);
    check("hex_lag_oseg", 64'(bus.oSEG), 64'(AllBlank));
    @(negedge clk);
    check("hex_beef", 64'(bus.oSEG),
          64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h03, 7'h06, 7'h06, 7'h0E}));
    check("hex_done_low", 64'(bus.done), 64'd0);

    // Decimal 12345678, no blanking
    d0 = done_total; b0 = busy_total;
    load_pulse(32'd12345678, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    check("dec_busy_cycles", 64'(busy_total - b0), 64'd26);
    check("dec_done_count", 64'(done_total - d0), 64'd1);
    check("dec_12345678", 64'(bus.oSEG),
          64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}));

    load_pulse(32'd0, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    check("dec_zero_lz", 64'(bus.oSEG), 64'({{7{7'h7F}}, 7'h40}));

    load_pulse(32'd1005, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    check("dec_1005_lz", 64'(bus.oSEG),
          64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h12}));

    // Loads during a conversion are ignored
    d0 = done_total; b0 = busy_total;
    load_pulse(32'd42, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #2 bus.load = 1'b1; bus.data = 32'd9; bus.dec_mode = 1'b1; bus.blank_lz = 1'b0;
    @(posedge clk);
    #2 bus.load = 1'b0;
    repeat (14) @(posedge clk);
    #2 bus.load = 1'b1; bus.data = 32'd9; bus.dec_mode = 1'b0;
    @(posedge clk);
    #2 bus.load = 1'b0;
    repeat (30) @(negedge clk);
    check("ignore_done_count", 64'(done_total - d0), 64'd1);
    check("ignore_busy_cycles", 64'(busy_total - b0), 64'd26);
    check("ignore_result_42", 64'(bus.oSEG), 64'({{6{7'h7F}}, 7'h19, 7'h24}));

    // Blink digit 0 showing hex 8
    load_pulse(32'h00000008, 1'b0, 1'b0);
    bus.blink_mask = 8'h01;
    repeat (3) @(negedge clk);
    blanks = 0; bad_upper = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.oSEG[6:0] == 7'h7F) blanks++;
      else if (bus.oSEG[6:0] != 7'h00) bad_upper++;
      if (bus.oSEG[55:7] != {7{7'h40}}) bad_upper++;
    end
    check("blink_blank_cycles", 64'(blanks), 64'd8);
    check("blink_other_digits", 64'(bad_upper), 64'd0);
    bus.blink_mask = 8'h00;

    // Reset in the middle of a conversion
    load_pulse(32'd999, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_oseg", 64'(bus.oSEG), 64'(AllBlank));
    check("midreset_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    d0 = done_total;
    repeat (35) @(negedge clk);
    check("midreset_no_done", 64'(done_total - d0), 64'd0);
    check("midreset_still_blank", 64'(bus.oSEG), 64'(AllBlank));
    load_pulse(32'h000000A5, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("after_reset_hex_a5", 64'(bus.oSEG), 64'({{6{7'h7F}}, 7'h08, 7'h12}));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_display_ctrl.md
# seg7_display_ctrl

Parametrised, registered driver for a bank of NUM_DIGITS active-low 7-segment displays. Replaces fixed per-digit hex lookup with a load-and-hold display register, a hex or decimal display mode (iterative binary-to-BCD conversion), leading-zero blanking and per-digit blinking. It sits between the debug/status datapath and the board's HEX display pins.

## Interface

- NUM_DIGITS, 8, number of digits driven (1..8)
- BIN_W, 26, binary input width used in decimal mode; elaboration error unless 2^BIN_W-1 < 10^NUM_DIGITS
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (>= 2)

- Clk  input  1  system clock, all state on rising edge
- Reset  input  1  asynchronous, active-high; clears all state
- load  input  1  one-cycle strobe; captures data, dec_mode, blank_lz when accepted
- data  input  4*NUM_DIGITS  hex mode: nibble k -> digit k; decimal mode: data[BIN_W-1:0] is the unsigned value
- dec_mode  input  1  0 = hex, 1 = decimal
- blank_lz  input  1  1 = blank leading zeros
- blink_mask  input  NUM_DIGITS  bit k = 1 blinks digit k; sampled live, not latched
- busy  output  1  conversion in progress; load ignored
- done  output  1  one-cycle pulse when a new value is committed
- oSEG  output  7*NUM_DIGITS  digit k at [7k+6:7k], bit0 = a .. bit6 = g, active-low

## Operation

- States: IDLE, CONV. Reset -> IDLE.
- IDLE, load=1, dec_mode=0: nibbles written to digit register on that edge; lz flag latched; done=1 next cycle; stay IDLE.
- IDLE, load=1, dec_mode=1: shift register <- data[BIN_W-1:0], BCD accumulator <- 0, bit counter <- 0, lz flag latched; -> CONV, busy=1.
- CONV: per cycle, add 3 to every BCD nibble >= 5, then shift left one bit taking next MSB of shift register. After BIN_W shifts: digit register <- BCD, done=1, busy=0, -> IDLE.
- load during CONV: ignored, no effect on conversion.
- Digit register and lz flag change only at commit; display otherwise holds.
- Display valid flag: 0 after reset, set at first commit; while 0 all digits blank.
- Leading-zero blanking (lz flag=1): digits above the most significant nonzero digit blanked; digit 0 never blanked by this rule (value 0 shows "0").
- Blink: free-running counter 0..BLINK_DIV-1; phase toggles on wrap. While phase=1, digits with blink_mask bit set are blanked.
- Glyphs (hex, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E; blank=7F.

## Timing

- Reset values: oSEG all 7'h7F, busy=0, done=0, phase=0, blink counter=0, valid=0, state IDLE.
- Reset mid-conversion: conversion aborted, display blank until next load.
- oSEG registered: reflects digit register, lz flag, valid, phase and blink_mask as of the previous edge (1-cycle lag).
- Hex latency: load sampled at edge T -> digit register at T, done high cycle after T, new oSEG after edge T+1.
- Decimal latency: load at edge T -> busy high after T, commit at edge T+BIN_W, done high for the cycle after T+BIN_W, oSEG after edge T+BIN_W+1. Next load accepted at edge T+BIN_W+1.
- Phase toggles every BLINK_DIV cycles exactly; blink_mask change visible on oSEG one edge later.
- load and commit never coincide (load ignored while busy).

## Test plan

- Hex, blank_lz=1, data=32'h0000BEEF -> after 2 edges oSEG digits 7..4 = 7F, digits 3..0 = 03,06,06,0E; done one pulse.
- Decimal, data=12345678 -> busy high exactly 26 cycles, then digits 7..0 = 1,2,3,4,5,6,7,8 glyphs; done one pulse.
- Decimal, blank_lz=1, data=0 -> digit 0 = 40, digits 7..1 = 7F; data=1005 -> digits 3..0 = 1,0,0,5, upper blank.
- load with data=9 asserted at cycles 5 and 20 of a conversion of 42 -> ignored; result 42, single done.
- BLINK_DIV=4, blink_mask=8'h01, hex 8 on digit 0 -> digit 0 alternates 00/7F every 4 cycles; other digits steady.
- Reset asserted mid-conversion -> oSEG all 7F, busy=0 immediately; no done; next hex load displays normally.
